// File: rtl/conv3x3_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Purpose  : Shared mode encodings, FSM states and frame defaults for the
//            3x3 convolution engine.
// Revision : 1.0
// ============================================================================
package conv_pkg;

  localparam int IMG_W_DEFAULT = 256;
  localparam int IMG_H_DEFAULT = 32;

  localparam logic MODE_GAUSS = 1'b0;
  localparam logic MODE_SHARP = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] sat_u8(input logic signed [11:0] v);
    logic [7:0] r;
    if (v < 12'sd0) begin
      r = 8'd0;
    end else if (v > 12'sd255) begin
      r = 8'hFF;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv3x3_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_engine_if
// Purpose  : Control, window-read and pixel-write signals of the engine.
// Revision : 1.0
// ============================================================================
interface conv3x3_engine_if;
  logic       start;
  logic       mode;
  logic       rd;
  logic [7:0] pixelr1;
  logic [7:0] pixelr2;
  logic [7:0] pixelr3;
  logic [7:0] pixelr4;
  logic [7:0] pixelr5;
  logic [7:0] pixelr6;
  logic [7:0] pixelr7;
  logic [7:0] pixelr8;
  logic [7:0] pixelr9;
  logic [7:0] pixelw;
  logic       wr;
  logic       busy;
  logic       done;

  modport slave (
    input  start, mode,
    input  pixelr1, pixelr2, pixelr3, pixelr4, pixelr5,
    input  pixelr6, pixelr7, pixelr8, pixelr9,
    output rd, pixelw, wr, busy, done
  );

  modport master (
    output start, mode,
    output pixelr1, pixelr2, pixelr3, pixelr4, pixelr5,
    output pixelr6, pixelr7, pixelr8, pixelr9,
    input  rd, pixelw, wr, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/conv3x3_engine_datapath.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_datapath
// Purpose  : Three-stage kernel pipeline (row sums, total, normalise).
// Revision : 1.0
// ============================================================================
module conv3x3_datapath
  import conv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_i,
  input  logic            mode_i,
  input  logic [8:0][7:0] win_i,
  output logic [7:0]      pixelw_o,
  output logic            wr_o,
  output logic            busy_o
);

  logic        win_vld_q;
  logic        s1_vld_q;
  logic        s2_vld_q;
  logic        wr_q;
  logic [10:0] s1_a_q, s1_a_d;
  logic [10:0] s1_b_q, s1_b_d;
  logic [9:0]  s1_c_q, s1_c_d;
  logic [11:0] s2_sum_q, s2_sum_d;
  logic [7:0]  pixelw_q, pixelw_d;

  // Gaussian: a/b/c are the three weighted rows. Sharpen: a = 5*centre, b = 4-neighbour sum.
  always_comb begin
    s1_a_d = '0;
    s1_b_d = '0;
    s1_c_d = '0;
    if (mode_i == MODE_GAUSS) begin
      s1_a_d = 11'(win_i[0]) + 11'({win_i[1], 1'b0}) + 11'(win_i[2]);
      s1_b_d = 11'({win_i[3], 1'b0}) + 11'({win_i[4], 2'b00}) + 11'({win_i[5], 1'b0});
      s1_c_d = 10'(win_i[6]) + 10'({win_i[7], 1'b0}) + 10'(win_i[8]);
    end else begin
      s1_a_d = 11'({win_i[4], 2'b00}) + 11'(win_i[4]);
      s1_b_d = 11'(win_i[1]) + 11'(win_i[3]) + 11'(win_i[5]) + 11'(win_i[7]);
    end
  end

  always_comb begin
    s2_sum_d = '0;
    if (mode_i == MODE_GAUSS) begin
      s2_sum_d = 12'(s1_a_q) + 12'(s1_b_q) + 12'(s1_c_q);
    end else begin
      s2_sum_d = 12'(s1_a_q) - 12'(s1_b_q);
    end
  end

  // Gaussian total tops out at 4080, so the rounded shift never exceeds 255.
  always_comb begin
    pixelw_d = '0;
    if (mode_i == MODE_GAUSS) begin
      pixelw_d = 8'((s2_sum_q + 12'd8) >> 4);
    end else begin
      pixelw_d = sat_u8($signed(s2_sum_q));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_vld_q <= 1'b0;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      wr_q      <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_c_q    <= '0;
      s2_sum_q  <= '0;
      pixelw_q  <= '0;
    end else begin
      win_vld_q <= rd_i;
      s1_vld_q  <= win_vld_q;
      s2_vld_q  <= s1_vld_q;
      wr_q      <= s2_vld_q;
      if (win_vld_q) begin
        s1_a_q <= s1_a_d;
        s1_b_q <= s1_b_d;
        s1_c_q <= s1_c_d;
      end
      if (s1_vld_q) begin
        s2_sum_q <= s2_sum_d;
      end
      if (s2_vld_q) begin
        pixelw_q <= pixelw_d;
      end
    end
  end

  assign pixelw_o = pixelw_q;
  assign wr_o     = wr_q;
  assign busy_o   = win_vld_q | s1_vld_q | s2_vld_q;

endmodule
`default_nettype wire

// File: rtl/conv3x3_engine.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_engine
// Purpose  : Frame sequencer: issues window reads, runs the kernel pipeline.
// Revision : 1.0
// ============================================================================
module conv3x3_engine
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int IMG_H = IMG_H_DEFAULT,
  parameter int CNT_W = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  conv3x3_engine_if.slave eng_if
);

  localparam int               N_PIX    = IMG_W * IMG_H;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIX - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rd_q;
  logic             busy_q;
  logic             done_q;
  logic             mode_q;

  logic [8:0][7:0]  w_win;
  logic [7:0]       w_pixelw;
  logic             w_wr;
  logic             w_pipe_busy;

  assign w_win[0] = eng_if.pixelr1;
  assign w_win[1] = eng_if.pixelr2;
  assign w_win[2] = eng_if.pixelr3;
  assign w_win[3] = eng_if.pixelr4;
  assign w_win[4] = eng_if.pixelr5;
  assign w_win[5] = eng_if.pixelr6;
  assign w_win[6] = eng_if.pixelr7;
  assign w_win[7] = eng_if.pixelr8;
  assign w_win[8] = eng_if.pixelr9;

  // DRAIN leaves once only the output stage can still be valid, so done lands right after the last wr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= MODE_GAUSS;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (eng_if.start) begin
            mode_q  <= eng_if.mode;
            cnt_q   <= '0;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          if (cnt_q == LAST_IDX) begin
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            state_q <= DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (!w_pipe_busy) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  conv3x3_datapath u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_i     (rd_q),
    .mode_i   (mode_q),
    .win_i    (w_win),
    .pixelw_o (w_pixelw),
    .wr_o     (w_wr),
    .busy_o   (w_pipe_busy)
  );

  assign eng_if.rd     = rd_q;
  assign eng_if.pixelw = w_pixelw;
  assign eng_if.wr     = w_wr;
  assign eng_if.busy   = busy_q;
  assign eng_if.done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv3x3_engine
// Purpose  : Directed bench with a window-memory model and expected-pixel queue.
// Revision : 1.0
// ============================================================================
module tb_conv3x3_engine;

  localparam int N_PIX = 8192;

  logic clk;
  logic rst_n;
  conv3x3_engine_if mif();

  conv3x3_engine dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .eng_if (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Window patterns (p1..p9) with hand-computed Gaussian and sharpen results.
  logic [7:0] pat   [5][9];
  logic [7:0] exp_g [5];
  logic [7:0] exp_s [5];
  logic       exp_mode;

  int cyc = 0;
  int rd_cnt, wr_cnt, done_cnt, pix_err, gap_err;
  int first_rd, first_wr, last_wr, done_at, win_idx;
  logic [7:0] expq[$];

  always @(posedge clk) cyc++;

  // Window memory: answers each rd with the next pattern one cycle later, zeros otherwise.
  bit rd_now;
  int k;
  initial begin
    {mif.pixelr1, mif.pixelr2, mif.pixelr3, mif.pixelr4, mif.pixelr5,
     mif.pixelr6, mif.pixelr7, mif.pixelr8, mif.pixelr9} = '0;
    forever begin
      @(negedge clk);
      rd_now = mif.rd;
      @(posedge clk);
      #1;
      if (rd_now) begin
        k = win_idx % 5;
        mif.pixelr1 = pat[k][0]; mif.pixelr2 = pat[k][1]; mif.pixelr3 = pat[k][2];
        mif.pixelr4 = pat[k][3]; mif.pixelr5 = pat[k][4]; mif.pixelr6 = pat[k][5];
        mif.pixelr7 = pat[k][6]; mif.pixelr8 = pat[k][7]; mif.pixelr9 = pat[k][8];
        expq.push_back(exp_mode ? exp_s[k] : exp_g[k]);
        win_idx++;
      end else begin
        {mif.pixelr1, mif.pixelr2, mif.pixelr3, mif.pixelr4, mif.pixelr5,
         mif.pixelr6, mif.pixelr7, mif.pixelr8, mif.pixelr9} = '0;
      end
    end
  end

  // Frame statistics gathered at the falling edge.
  logic [7:0] e;
  always @(negedge clk) begin
    if (mif.rd === 1'b1) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (mif.wr === 1'b1) begin
      if (wr_cnt > 0 && last_wr != cyc - 1) gap_err++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      wr_cnt++;
      if (expq.size() == 0) begin
        pix_err++;
      end else begin
        e = expq.pop_front();
        if (mif.pixelw !== e) pix_err++;
      end
    end
    if (mif.done === 1'b1) begin
      done_cnt++;
      done_at = cyc;
    end
  end

  task automatic clear_stats();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; pix_err = 0; gap_err = 0;
    first_rd = -1; first_wr = -1; last_wr = -1; done_at = -1; win_idx = 0;
    expq.delete();
  endtask

  task automatic pulse_start(input logic m);
    @(posedge clk);
    #1;
    mif.start = 1'b1;
    mif.mode  = m;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if (mif.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mif.start = 1'b0;
    mif.mode = 1'b0;
    exp_mode = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (mif.rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b want 0", mif.rd); end
    n_chk++; if (mif.wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", mif.wr); end
    n_chk++; if (mif.pixelw !== 8'd0) begin n_fail++; $display("FAIL reset_pixelw: got %0d want 0", mif.pixelw); end
    n_chk++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", mif.busy); end
    n_chk++; if (mif.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", mif.done); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_gaussian();
    bit ok;
    clear_stats();
    exp_mode = 1'b0;
    pulse_start(1'b0);
    wait_done(ok);
    @(posedge clk);
    #1;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL gauss_done_seen: got 0 want 1"); end
    n_chk++; if (rd_cnt !== N_PIX) begin n_fail++; $display("FAIL gauss_rd_count: got %0d want %0d", rd_cnt, N_PIX); end
    n_chk++; if (wr_cnt !== N_PIX) begin n_fail++; $display("FAIL gauss_wr_count: got %0d want %0d", wr_cnt, N_PIX); end
    n_chk++; if (pix_err !== 0) begin n_fail++; $display("FAIL gauss_pixels: got %0d wrong want 0", pix_err); end
    n_chk++; if (gap_err !== 0) begin n_fail++; $display("FAIL gauss_wr_contig: got %0d gaps want 0", gap_err); end
    n_chk++; if (first_wr - first_rd !== 4) begin n_fail++; $display("FAIL gauss_latency: got %0d want 4", first_wr - first_rd); end
    n_chk++; if (done_at - last_wr !== 1) begin n_fail++; $display("FAIL gauss_done_after_wr: got %0d want 1", done_at - last_wr); end
    n_chk++; if (mif.pixelw !== 8'd64) begin n_fail++; $display("FAIL gauss_pixelw_hold: got %0d want 64", mif.pixelw); end
    n_chk++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL gauss_busy_idle: got %b want 0", mif.busy); end
  endtask

  task automatic test_sharpen_mode_toggle();
    bit ok;
    clear_stats();
    exp_mode = 1'b1;
    pulse_start(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if (mif.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (i % 37 == 0) mif.mode = ~mif.mode;
    end
    @(posedge clk);
    #1;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL sharp_done_seen: got 0 want 1"); end
    n_chk++; if (wr_cnt !== N_PIX) begin n_fail++; $display("FAIL sharp_wr_count: got %0d want %0d", wr_cnt, N_PIX); end
    n_chk++; if (pix_err !== 0) begin n_fail++; $display("FAIL sharp_pixels: got %0d wrong want 0", pix_err); end
    n_chk++; if (mif.pixelw !== 8'd255) begin n_fail++; $display("FAIL sharp_pixelw_hold: got %0d want 255", mif.pixelw); end
    n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL sharp_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_ignored();
    bit ok;
    clear_stats();
    exp_mode = 1'b0;
    pulse_start(1'b0);
    repeat (100) @(posedge clk);
    pulse_start(1'b1);
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if (mif.rd !== 1'b1) break;
    end
    pulse_start(1'b1);
    wait_done(ok);
    repeat (20) @(posedge clk);
    #1;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL ign_done_seen: got 0 want 1"); end
    n_chk++; if (rd_cnt !== N_PIX) begin n_fail++; $display("FAIL ign_rd_count: got %0d want %0d", rd_cnt, N_PIX); end
    n_chk++; if (wr_cnt !== N_PIX) begin n_fail++; $display("FAIL ign_wr_count: got %0d want %0d", wr_cnt, N_PIX); end
    n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
    n_chk++; if (pix_err !== 0) begin n_fail++; $display("FAIL ign_pixels: got %0d wrong want 0", pix_err); end
    n_chk++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy_idle: got %b want 0", mif.busy); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int snap_wr, snap_done;
    clear_stats();
    exp_mode = 1'b0;
    pulse_start(1'b0);
    wait_done(ok);
    @(posedge clk);
    #1;
    snap_wr = wr_cnt;
    snap_done = done_cnt;
    clear_stats();
    mif.start = 1'b1;
    mif.mode  = 1'b0;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    n_chk++; if (snap_wr !== N_PIX) begin n_fail++; $display("FAIL b2b_first_wr_count: got %0d want %0d", snap_wr, N_PIX); end
    n_chk++; if (snap_done !== 1) begin n_fail++; $display("FAIL b2b_first_done_count: got %0d want 1", snap_done); end
    n_chk++; if (mif.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_start_accepted: got %b want 1", mif.busy); end
    wait_done(ok);
    @(posedge clk);
    #1;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_second_done_seen: got 0 want 1"); end
    n_chk++; if (wr_cnt !== N_PIX) begin n_fail++; $display("FAIL b2b_second_wr_count: got %0d want %0d", wr_cnt, N_PIX); end
    n_chk++; if (pix_err !== 0) begin n_fail++; $display("FAIL b2b_second_pixels: got %0d wrong want 0", pix_err); end
    n_chk++; if (first_wr - first_rd !== 4) begin n_fail++; $display("FAIL b2b_latency: got %0d want 4", first_wr - first_rd); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    clear_stats();
    exp_mode = 1'b0;
    pulse_start(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      if (rd_cnt >= 3000) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rst_reach_3000: got %0d want 3000", rd_cnt); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (mif.rd !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rd: got %b want 0", mif.rd); end
    n_chk++; if (mif.wr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wr: got %b want 0", mif.wr); end
    n_chk++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", mif.busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    repeat (30) @(negedge clk);
    #1;
    n_chk++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL rst_no_wr_after: got %0d want 0", wr_cnt); end
    n_chk++; if (rd_cnt !== 0) begin n_fail++; $display("FAIL rst_no_rd_after: got %0d want 0", rd_cnt); end
    clear_stats();
    pulse_start(1'b0);
    wait_done(ok);
    @(posedge clk);
    #1;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rst_next_done_seen: got 0 want 1"); end
    n_chk++; if (wr_cnt !== N_PIX) begin n_fail++; $display("FAIL rst_next_wr_count: got %0d want %0d", wr_cnt, N_PIX); end
    n_chk++; if (pix_err !== 0) begin n_fail++; $display("FAIL rst_next_pixels: got %0d wrong want 0", pix_err); end
  endtask

  initial begin
    pat[0] = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    pat[1] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd255, 8'd0,   8'd0,   8'd0,   8'd0};
    pat[2] = '{8'd16,  8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
    pat[3] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0,   8'd255, 8'd255, 8'd255, 8'd255};
    pat[4] = '{8'd40,  8'd40,  8'd40,  8'd40,  8'd50,  8'd40,  8'd40,  8'd40,  8'd40};
    exp_g  = '{8'd100, 8'd64, 8'd1, 8'd191, 8'd43};
    exp_s  = '{8'd100, 8'd255, 8'd0, 8'd0, 8'd90};

    test_reset();
    test_gaussian();
    test_sharpen_mode_toggle();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
